// File: rtl/mem_dual_stage_if.sv
// Execute-to-memory, SRAM read data and memory-to-writeback/forwarding bundles
// for the dual-issue memory stage.
interface mem_dual_stage_if #(
  parameter int SLOT_WD = 74
);
  logic [2*SLOT_WD+2:0] ex_to_mem_bus;
  logic [31:0]          data_sram_rdata;
  logic [141:0]         mem_to_wb_bus;
  logic [75:0]          mem_to_rf_bus;

  modport master (
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_rf_bus
  );

  modport slave (
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_rf_bus
  );
endinterface

// File: rtl/mem_dual_stage.sv
// Dual-issue memory stage: registers the execute pair, completes loads from
// SRAM read data and keeps that data alive across writeback stalls.
module mem_dual_stage #(
  parameter int SLOT_WD  = 74,
  parameter int STALL_WD = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [STALL_WD-1:0] stall,
  mem_dual_stage_if.slave     bus
);

  localparam int R_WD = 2*SLOT_WD+3;

  logic [R_WD-1:0] r_stage;
  logic            r_first;
  logic            r_hold_v;
  logic [31:0]     r_hold_d;

  logic        w_stop;
  logic        w_wb_stop;
  logic        w_clear;
  logic [31:0] w_src;
  logic [69:0] w_wb_lo;
  logic [69:0] w_wb_hi;
  logic        w_unused;

  assign w_stop    = stall[4];
  assign w_wb_stop = stall[5];
  assign w_clear   = flush | (w_stop & ~w_wb_stop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage  <= '0;
      r_first  <= 1'b0;
      r_hold_v <= 1'b0;
      r_hold_d <= '0;
    end else if (w_clear) begin
      r_stage  <= '0;
      r_first  <= 1'b0;
      r_hold_v <= 1'b0;
    end else if (!w_stop) begin
      r_stage  <= bus.ex_to_mem_bus;
      r_first  <= 1'b1;
      r_hold_v <= 1'b0;
    end else begin
      r_first <= 1'b0;
      // SRAM data is only valid in the first cycle; capture it once
      if (r_first) begin
        r_hold_d <= bus.data_sram_rdata;
        r_hold_v <= 1'b1;
      end
    end
  end

  assign w_src = r_first  ? bus.data_sram_rdata :
                 r_hold_v ? r_hold_d : 32'd0;

  function automatic logic [69:0] f_wb(
    input logic [73:0] s,
    input logic        v,
    input logic [31:0] d
  );
    logic [31:0] res;
    logic [31:0] wd;
    logic [7:0]  b;
    logic [15:0] h;
    res = s[31:0];
    unique case (res[1:0])
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = res[1] ? d[31:16] : d[15:0];
    if (s[35]) begin
      case (s[34:32])
        3'd0: wd = {{24{b[7]}}, b};
        3'd1: wd = {24'd0, b};
        3'd2: wd = {{16{h[15]}}, h};
        3'd3: wd = {16'd0, h};
        3'd4: wd = d;
        default: wd = 32'd0;
      endcase
    end else begin
      wd = res;
    end
    if (v) f_wb = {s[73:42], s[41], s[40:36], wd};
    else   f_wb = {s[73:42], 38'd0};
  endfunction

  assign w_wb_lo = f_wb(r_stage[SLOT_WD-1:0],
                        r_stage[2*SLOT_WD], w_src);
  assign w_wb_hi = f_wb(r_stage[2*SLOT_WD-1:SLOT_WD],
                        r_stage[2*SLOT_WD+1], w_src);

  assign bus.mem_to_wb_bus = {r_stage[2*SLOT_WD+1],
                              r_stage[2*SLOT_WD],
                              w_wb_hi, w_wb_lo};
  assign bus.mem_to_rf_bus = {w_wb_hi[37:0], w_wb_lo[37:0]};

  // switch is trace-only; low stall bits belong to other stages
  assign w_unused = ^{r_stage[2*SLOT_WD+2], stall[3:0]};

endmodule

// File: tb/tb_mem_dual_stage.sv
// Randomized and directed bench for mem_dual_stage against a
// slot-level behavioural model.
module tb_mem_dual_stage;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic        ld;
    logic [2:0]  lt;
    logic [31:0] res;
  } slot_t;

  localparam logic [2:0]  LD_LT   [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
  localparam logic [1:0]  LD_ADDR [5] = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd0};
  localparam logic [31:0] LD_EXP  [5] = '{32'h0000007F, 32'hFFFFFF80,
                                          32'h00000080, 32'hFFFF80FF,
                                          32'h80FF7F01};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] stall = 6'd0;

  slot_t       in_lo, in_hi;
  logic        in_vlo = 1'b0;
  logic        in_vhi = 1'b0;
  logic        in_sw = 1'b0;
  logic [31:0] rdata = 32'd0;

  slot_t       m_lo, m_hi;
  logic        m_vlo, m_vhi, m_fresh;
  logic [31:0] m_seen;

  int n_total = 0;
  int n_bad = 0;

  mem_dual_stage_if #(.SLOT_WD(74)) ifc ();

  mem_dual_stage #(.SLOT_WD(74), .STALL_WD(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [73:0] pack(slot_t s);
    return {s.pc, s.we, s.waddr, s.ld, s.lt, s.res};
  endfunction

  assign ifc.ex_to_mem_bus = {in_sw, in_vhi, in_vlo, pack(in_hi), pack(in_lo)};
  assign ifc.data_sram_rdata = rdata;

  function automatic slot_t mk(logic [31:0] pc, logic we, logic [4:0] wa,
                               logic ld, logic [2:0] lt, logic [31:0] res);
    slot_t s;
    s.pc = pc; s.we = we; s.waddr = wa;
    s.ld = ld; s.lt = lt; s.res = res;
    return s;
  endfunction

  function automatic slot_t rnd_slot(logic ld);
    return mk($urandom, 1'($urandom), 5'($urandom), ld,
              3'($urandom), $urandom);
  endfunction

  // Little-endian byte/half extraction with sign handling by arithmetic
  function automatic logic [31:0] load_val(logic [2:0] lt, logic [31:0] a,
                                           logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (lt)
      3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1: return b;
      3'd2: return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd3: return h;
      3'd4: return d;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [69:0] exp_rec(slot_t s, logic v, logic [31:0] d);
    if (!v) return {s.pc, 38'd0};
    return {s.pc, s.we, s.waddr, s.ld ? load_val(s.lt, s.res, d) : s.res};
  endfunction

  function automatic logic [141:0] exp_wb();
    logic [31:0] d;
    d = m_fresh ? rdata : m_seen;
    return {m_vhi, m_vlo, exp_rec(m_hi, m_vhi, d), exp_rec(m_lo, m_vlo, d)};
  endfunction

  function automatic logic [75:0] exp_rf();
    logic [141:0] w;
    w = exp_wb();
    return {w[107:70], w[37:0]};
  endfunction

  task automatic model_reset();
    m_lo = mk(0, 0, 0, 0, 0, 0);
    m_hi = mk(0, 0, 0, 0, 0, 0);
    m_vlo = 1'b0; m_vhi = 1'b0;
    m_fresh = 1'b0; m_seen = 32'd0;
  endtask

  // A load keeps the data that was on the SRAM port during its first cycle
  task automatic model_edge();
    if (flush || (stall[4] && !stall[5])) begin
      m_lo = mk(0, 0, 0, 0, 0, 0);
      m_hi = mk(0, 0, 0, 0, 0, 0);
      m_vlo = 1'b0; m_vhi = 1'b0; m_fresh = 1'b0;
    end else if (!stall[4]) begin
      m_lo = in_lo; m_hi = in_hi;
      m_vlo = in_vlo; m_vhi = in_vhi; m_fresh = 1'b1;
    end else begin
      if (m_fresh) m_seen = rdata;
      m_fresh = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_lo = mk(0, 0, 0, 0, 0, 0);
    in_hi = mk(0, 0, 0, 0, 0, 0);
    in_vlo = 1'b0; in_vhi = 1'b0; in_sw = 1'b0;
    stall = 6'd0; flush = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus !== 142'd0 || ifc.mem_to_rf_bus !== 76'd0) begin
      n_bad++;
      $display("FAIL reset_out wb=%h rf=%h required 0",
               ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      #1;
      n_total++;
      if (ifc.mem_to_wb_bus !== 142'd0 || ifc.mem_to_rf_bus !== 76'd0) begin
        n_bad++;
        $display("FAIL idle_out[%0d] wb=%h rf=%h required 0",
                 i, ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
      end
    end
  endtask

  task automatic test_alu();
    in_lo = mk(32'hBFC00000, 1, 5'd3, 0, 0, 32'h12345678);
    in_hi = mk(32'hBFC00004, 1, 5'd4, 0, 0, 32'h0000000A);
    in_vlo = 1'b1; in_vhi = 1'b1; in_sw = 1'b1;
    cycle();
    set_idle();
    rdata = $urandom;
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus[31:0] !== 32'h12345678 ||
        ifc.mem_to_wb_bus[101:70] !== 32'h0000000A) begin
      n_bad++;
      $display("FAIL alu_wdata lo=%h hi=%h required 12345678/0000000a",
               ifc.mem_to_wb_bus[31:0], ifc.mem_to_wb_bus[101:70]);
    end
    n_total++;
    if (ifc.mem_to_rf_bus !== {1'b1, 5'd4, 32'hA, 1'b1, 5'd3, 32'h12345678}) begin
      n_bad++;
      $display("FAIL alu_fwd got=%h", ifc.mem_to_rf_bus);
    end
    n_total++;
    if (ifc.mem_to_wb_bus !== exp_wb()) begin
      n_bad++;
      $display("FAIL alu_wb got=%h required=%h", ifc.mem_to_wb_bus, exp_wb());
    end
  endtask

  task automatic test_back_to_back_loads();
    slot_t ld, alu;
    logic [31:0] got;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        alu = mk($urandom, 1, 5'(i + 1), 0, 0, $urandom);
        ld = mk(32'h80000100, 1, 5'(i + 10), 1, LD_LT[i],
                32'h10000000 | 32'(LD_ADDR[i]));
        if (k == 0) begin in_lo = ld; in_hi = alu; end
        else begin in_lo = alu; in_hi = ld; end
        in_vlo = 1'b1; in_vhi = 1'b1; stall = 6'd0;
        cycle();
        rdata = 32'h80FF7F01;
        #1;
        got = (k == 0) ? ifc.mem_to_wb_bus[31:0] : ifc.mem_to_wb_bus[101:70];
        n_total++;
        if (got !== LD_EXP[i]) begin
          n_bad++;
          $display("FAIL load_%0d_slot%0d got=%h required=%h",
                   i, k, got, LD_EXP[i]);
        end
        n_total++;
        if (ifc.mem_to_wb_bus !== exp_wb()) begin
          n_bad++;
          $display("FAIL load_wb_%0d_slot%0d got=%h required=%h",
                   i, k, ifc.mem_to_wb_bus, exp_wb());
        end
      end
    end
    set_idle();
  endtask

  task automatic test_stall_load();
    set_idle();
    in_lo = mk(32'h80000200, 1, 5'd7, 1, 3'd4, 32'h00002000);
    in_vlo = 1'b1;
    cycle();
    set_idle();
    stall = 6'b110000;
    rdata = 32'hDEADBEEF;
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus[31:0] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL stall_first got=%h required=deadbeef",
               ifc.mem_to_wb_bus[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      rdata = 32'd0;
      #1;
      n_total++;
      if (ifc.mem_to_wb_bus[31:0] !== 32'hDEADBEEF ||
          ifc.mem_to_rf_bus[31:0] !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] wb=%h rf=%h required=deadbeef",
                 i, ifc.mem_to_wb_bus[31:0], ifc.mem_to_rf_bus[31:0]);
      end
    end
    stall = 6'd0;
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus[31:0] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL stall_release got=%h required=deadbeef",
               ifc.mem_to_wb_bus[31:0]);
    end
    cycle();
    rdata = $urandom;
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus !== 142'd0) begin
      n_bad++;
      $display("FAIL stall_after got=%h required 0", ifc.mem_to_wb_bus);
    end
  endtask

  task automatic test_bubble();
    in_lo = rnd_slot(0); in_hi = rnd_slot(0);
    in_vlo = 1'b1; in_vhi = 1'b1;
    cycle();
    stall = 6'b010000;
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus[141:140] !== 2'b11) begin
      n_bad++;
      $display("FAIL bubble_pre valid=%b required=11",
               ifc.mem_to_wb_bus[141:140]);
    end
    cycle();
    set_idle();
    #1;
    n_total++;
    if (ifc.mem_to_wb_bus !== 142'd0 || ifc.mem_to_rf_bus !== 76'd0) begin
      n_bad++;
      $display("FAIL bubble wb=%h rf=%h required 0",
               ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
    end
  endtask

  task automatic test_kill_mid_load();
    for (int mode = 0; mode < 2; mode++) begin
      set_idle();
      in_lo = mk(32'h80000300, 1, 5'd9, 1, 3'd4, 32'h00003000);
      in_vlo = 1'b1;
      cycle();
      set_idle();
      stall = 6'b110000;
      rdata = 32'h11111111;
      cycle();
      rdata = 32'd0;
      if (mode == 0) begin
        flush = 1'b1;
        cycle();
        flush = 1'b0;
      end else begin
        rst = 1'b0;
        #1;
        model_reset();
        #1;
        rst = 1'b1;
      end
      #1;
      n_total++;
      if (ifc.mem_to_wb_bus !== 142'd0 || ifc.mem_to_rf_bus !== 76'd0) begin
        n_bad++;
        $display("FAIL kill_%0d wb=%h rf=%h required 0",
                 mode, ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
      end
      stall = 6'd0;
      in_lo = mk(32'h80000400, 1, 5'd10, 1, 3'd4, 32'h00004000);
      in_vlo = 1'b1;
      cycle();
      set_idle();
      stall = 6'b110000;
      rdata = 32'h22222222;
      #1;
      n_total++;
      if (ifc.mem_to_wb_bus[31:0] !== 32'h22222222) begin
        n_bad++;
        $display("FAIL kill_%0d_fresh got=%h required=22222222",
                 mode, ifc.mem_to_wb_bus[31:0]);
      end
      cycle();
      rdata = 32'h33333333;
      #1;
      n_total++;
      if (ifc.mem_to_wb_bus[31:0] !== 32'h22222222) begin
        n_bad++;
        $display("FAIL kill_%0d_rehold got=%h required=22222222",
                 mode, ifc.mem_to_wb_bus[31:0]);
      end
      stall = 6'd0;
      cycle();
    end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 2));
      in_lo = rnd_slot(sel == 1);
      in_hi = rnd_slot(sel == 2);
      in_vlo = 1'($urandom); in_vhi = 1'($urandom); in_sw = 1'($urandom);
      stall = 6'($urandom);
      if ($urandom_range(0, 1) == 0) stall[5:4] = 2'b00;
      flush = ($urandom_range(0, 15) == 0);
      cycle();
      rdata = $urandom;
      #1;
      n_total++;
      if (ifc.mem_to_wb_bus !== exp_wb()) begin
        n_bad++;
        $display("FAIL rand_wb[%0d] got=%h required=%h",
                 i, ifc.mem_to_wb_bus, exp_wb());
      end
      n_total++;
      if (ifc.mem_to_rf_bus !== exp_rf()) begin
        n_bad++;
        $display("FAIL rand_rf[%0d] got=%h required=%h",
                 i, ifc.mem_to_rf_bus, exp_rf());
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_alu();
    test_back_to_back_loads();
    test_stall_load();
    test_bubble();
    test_kill_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dual_stage.md
Name: mem_dual_stage

Overview:
- Memory stage of the dual-issue pipeline, directly downstream of the execute stage.
- Registers the two-slot execute-to-memory bundle and completes loads using data SRAM read data, which returns one cycle after execute issued the request.
- Drives the memory-to-writeback bundle and the per-slot forwarding bus back to the register-file bypass network.
- Holds the SRAM read data across writeback stalls so a stalled load never loses its data.

Parameters:
- SLOT_WD, 74: width of one slot record `{pc[31:0], we, waddr[4:0], load_en, load_type[2:0], ex_result[31:0]}`.
- STALL_WD, 6: width of the stall vector.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- flush  input  1  synchronous clear of the stage register.
- stall  input  STALL_WD  per-stage stall vector; bit 4 = this stage, bit 5 = writeback.
- ex_to_mem_bus  input  2*SLOT_WD+3  `{switch, v_hi, v_lo, slot_hi, slot_lo}`; slot_lo is the older instruction.
- data_sram_rdata  input  32  read data for the load issued by execute in the previous cycle.
- mem_to_wb_bus  output  2*70+2  `{v_hi, v_lo, wb_hi, wb_lo}`; each wb record is `{pc[31:0], we, waddr[4:0], wdata[31:0]}`.
- mem_to_rf_bus  output  76  `{we_hi, waddr_hi, wdata_hi, we_lo, waddr_lo, wdata_lo}`, forwarding.

Behaviour:
- Stage register R (2*SLOT_WD+3 bits), priority order at posedge clk:
  - rst==0 (asynchronous): R cleared.
  - flush: R cleared.
  - stall[4]==Stop and stall[5]==NoStop: R cleared (bubble).
  - stall[4]==NoStop: R loads ex_to_mem_bus.
  - Otherwise R holds.
- Slot invalidation: a slot whose valid bit is 0 drives we=0, waddr=0, wdata=0 on both outputs; pc still passes through.
- Load constraint: at most one slot per pair has load_en=1. This is guaranteed upstream and not checked here.
- Load data selection:
  - Byte lane is ex_result[1:0]; data is little-endian.
  - load_type 0 = lb: lane byte, sign-extended.
  - 1 = lbu: lane byte, zero-extended.
  - 2 = lh: half at ex_result[1]*16, sign-extended.
  - 3 = lhu: same half, zero-extended.
  - 4 = lw: full word.
  - 5–7: wdata=0.
- Non-load slot: wdata = ex_result.
- Read-data hold buffer (hold_valid, hold_data):
  - Purpose: data_sram_rdata is valid only in the first cycle after R captures a load.
  - first_cycle is a flag set when R loaded new contents at the last edge, cleared otherwise; reset 0.
  - Source data = first_cycle ? data_sram_rdata : hold_data.
  - On every edge where first_cycle==1 and R holds (stall[4]==Stop): hold_data <= data_sram_rdata and hold_valid <= 1.
  - hold_valid clears whenever R loads, clears, or flushes.
  - Reset: hold_valid=0, hold_data=0.
  - A second stalled cycle keeps the held data; the buffer is never re-sampled.
- Forwarding: mem_to_rf_bus is combinational from R plus the load mux, available in the same cycle. During stall it reflects the held instruction with correct load data.
- Latency: one register stage; the writeback record of a pair appears the cycle after it leaves execute.
- switch: carried in R for trace ordering only. It does not alter the packing; slot_lo is always the older instruction.
- Reset/flush mid-load: the hold buffer is discarded and no stale data reaches writeback.
- Reset values: R=0, so both outputs are all-zero and first_cycle=0.

Test Plan:
- Reset then idle, stall=0, bus=0 → mem_to_wb_bus==0 and mem_to_rf_bus==0 every cycle.
- ALU pair: lo = `{pc=0xBFC00000, we=1, waddr=3, ex_result=0x12345678}`, hi = `{we=1, waddr=4, ex_result=0xA}`, both valid → next cycle wdata_lo=0x12345678, wdata_hi=0xA, both forwarding entries valid.
- Loads with data_sram_rdata=0x80FF7F01:
  - lb at addr 1 → wdata 0x0000007F.
  - lb at addr 3 → 0xFFFFFF80.
  - lbu at addr 3 → 0x00000080.
  - lh at addr 2 → 0xFFFF80FF.
  - lw → 0x80FF7F01.
- Stalled load: lw captured with rdata=0xDEADBEEF, then stall[5:4]=11 for 3 cycles while rdata changes to 0x0 → wdata stays 0xDEADBEEF in all 3 cycles and after release.
- Bubble: stall[4]=1, stall[5]=0 → next cycle R cleared and both valid bits 0.
- Flush or rst=0 asserted during a stalled load → outputs 0 and hold_valid=0. A following fresh load uses the new data_sram_rdata.
